seq_alu: RTL

Parametrised, handshaked successor to the execute-stage ALU. Registered single-cycle integer ops plus iterative multiply/divide (RISC-V M semantics), all behind one valid/ready interface. Sits between decode/register-read and writeback. Stalls the front end via `in_ready` while a multi-cycle op is in flight.

---
 rtl/seq_alu_pkg.sv | 34 +++
 rtl/seq_alu_if.sv | 24 ++
 rtl/seq_alu_muldiv_iter.sv | 98 +++++++++
 rtl/seq_alu.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared op codes, FSM states and op classification for seq_alu.
package alu_pkg;

  localparam logic [4:0] OP_AND   = 5'b00000;
  localparam logic [4:0] OP_OR    = 5'b00001;
  localparam logic [4:0] OP_ADD   = 5'b00010;
  localparam logic [4:0] OP_SLL   = 5'b00011;
  localparam logic [4:0] OP_SLTU  = 5'b00100;
  localparam logic [4:0] OP_SLT   = 5'b00101;
  localparam logic [4:0] OP_SUB   = 5'b00110;
  localparam logic [4:0] OP_XOR   = 5'b00111;
  localparam logic [4:0] OP_SRL   = 5'b01000;
  localparam logic [4:0] OP_SRA   = 5'b01010;
  localparam logic [4:0] OP_MUL   = 5'b10000;
  localparam logic [4:0] OP_MULHU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10100;
  localparam logic [4:0] OP_DIVU  = 5'b10101;
  localparam logic [4:0] OP_REM   = 5'b10110;
  localparam logic [4:0] OP_REMU  = 5'b10111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [4:0] op);
    case (op)
      OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU: is_muldiv = 1'b1;
      default: is_muldiv = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle of seq_alu; master drives ops and consumes results.
interface seq_alu_if #(parameter int N = 32);
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   op;
  logic [N-1:0] rs1;
  logic [N-1:0] rs2;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] res;
  logic         zf;
  logic         negative;
  logic         busy;

  modport master (
    output in_valid, op, rs1, rs2, out_ready,
    input  in_ready, out_valid, res, zf, negative, busy
  );

  modport slave (
    input  in_valid, op, rs1, rs2, out_ready,
    output in_ready, out_valid, res, zf, negative, busy
  );
endinterface

// File: rtl/seq_alu_muldiv_iter.sv
// Radix-2 iterative multiplier / restoring divider; present only with SEQ_ALU_MULDIV_EN.
// The Nth step is evaluated combinationally so the result is valid while done is high.
`ifdef SEQ_ALU_MULDIV_EN
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [4:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [N-1:0]  hi_r, lo_r, b_r;
  logic [4:0]    op_r;
  logic          neg_q_r, neg_rem_r, run_r;
  logic [CW-1:0] cnt_r;

  logic [N:0]    sum_s, shifted_s, diff_s;
  logic [N-1:0]  hi_s, lo_s, q_s, r_s, a_mag_s, b_mag_s;
  logic          sgn_s, is_mul_s;

  assign sgn_s     = (op == OP_DIV) || (op == OP_REM);
  assign a_mag_s   = (sgn_s && a[N-1]) ? -a : a;
  assign b_mag_s   = (sgn_s && b[N-1]) ? -b : b;
  assign is_mul_s  = (op_r == OP_MUL) || (op_r == OP_MULHU);
  assign sum_s     = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(N+1){1'b0}});
  assign shifted_s = {hi_r, lo_r[N-1]};
  assign diff_s    = shifted_s - {1'b0, b_r};
  assign done      = run_r && (cnt_r == LAST);

  // One shift-add or restoring-subtract step plus sign fix-up of the outcome
  always_comb begin
    hi_s   = {N{1'b0}};
    lo_s   = {N{1'b0}};
    result = {N{1'b0}};
    if (is_mul_s) begin
      hi_s = sum_s[N:1];
      lo_s = {sum_s[0], lo_r[N-1:1]};
    end else if (!diff_s[N]) begin
      hi_s = diff_s[N-1:0];
      lo_s = {lo_r[N-2:0], 1'b1};
    end else begin
      hi_s = shifted_s[N-1:0];
      lo_s = {lo_r[N-2:0], 1'b0};
    end
    q_s = neg_q_r ? -lo_s : lo_s;
    r_s = neg_rem_r ? -hi_s : hi_s;
    case (op_r)
      OP_MUL:           result = lo_s;
      OP_MULHU:         result = hi_s;
      OP_DIV, OP_DIVU:  result = q_s;
      OP_REM, OP_REMU:  result = r_s;
      default:          result = {N{1'b0}};
    endcase
  end

  // Operand capture on start, then one iteration per cycle until done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r      <= {N{1'b0}};
      lo_r      <= {N{1'b0}};
      b_r       <= {N{1'b0}};
      op_r      <= 5'b00000;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      run_r     <= 1'b0;
      cnt_r     <= {CW{1'b0}};
    end else if (start) begin
      hi_r      <= {N{1'b0}};
      lo_r      <= a_mag_s;
      b_r       <= b_mag_s;
      op_r      <= op;
      neg_q_r   <= (op == OP_DIV) && (a[N-1] ^ b[N-1]);
      neg_rem_r <= (op == OP_REM) && a[N-1];
      run_r     <= 1'b1;
      cnt_r     <= {CW{1'b0}};
    end else if (done) begin
      run_r <= 1'b0;
      cnt_r <= {CW{1'b0}};
    end else if (run_r) begin
      hi_r  <= hi_s;
      lo_r  <= lo_s;
      cnt_r <= cnt_r + ONE;
    end
  end

endmodule
`endif

// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU: registered single-cycle ops plus iterative
// RISC-V M ops when SEQ_ALU_MULDIV_EN is defined (otherwise M codes return 0).
module seq_alu
  import alu_pkg::*;
#(
  parameter int N  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic       clk,
  input  logic       rst,
  seq_alu_if.slave   bus
);

  state_t        state_r, state_s;
  logic          in_ready_s, accept_s, multi_s;
  logic          load_quick_s, load_md_s;
  logic          md_done_s;
  logic [N-1:0]  md_res_s, quick_s, res_nxt_s, res_r;
  logic          zf_r, neg_r;
  logic [SW-1:0] sh_s;

  assign in_ready_s = (state_r == ST_IDLE) || ((state_r == ST_DONE) && bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign sh_s       = bus.rs2[SW-1:0];

`ifdef SEQ_ALU_MULDIV_EN
  logic div0_s, ovf_s, special_s;

  assign div0_s = (bus.rs2 == {N{1'b0}});
  assign ovf_s  = (bus.rs1 == {1'b1, {(N-1){1'b0}}}) && (bus.rs2 == {N{1'b1}});

  // Divide-by-zero and signed overflow bypass the iterative unit
  always_comb begin
    special_s = 1'b0;
    case (bus.op)
      OP_DIV, OP_REM:   special_s = div0_s || ovf_s;
      OP_DIVU, OP_REMU: special_s = div0_s;
      default:          special_s = 1'b0;
    endcase
  end

  assign multi_s  = is_muldiv(bus.op) && !special_s;
  assign bus.busy = (state_r == ST_CALC);

  muldiv_iter #(.N(N)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (accept_s && multi_s),
    .op     (bus.op),
    .a      (bus.rs1),
    .b      (bus.rs2),
    .done   (md_done_s),
    .result (md_res_s)
  );
`else
  assign multi_s   = 1'b0;
  assign md_done_s = 1'b0;
  assign md_res_s  = {N{1'b0}};
  assign bus.busy  = 1'b0;
`endif

  // Single-cycle result from the operands presented at accept
  always_comb begin
    quick_s = {N{1'b0}};
    case (bus.op)
      OP_AND:  quick_s = bus.rs1 & bus.rs2;
      OP_OR:   quick_s = bus.rs1 | bus.rs2;
      OP_ADD:  quick_s = bus.rs1 + bus.rs2;
      OP_SLL:  quick_s = bus.rs1 << sh_s;
      OP_SLTU: quick_s = {{(N-1){1'b0}}, (bus.rs1 < bus.rs2)};
      OP_SLT:  quick_s = {{(N-1){1'b0}}, ($signed(bus.rs1) < $signed(bus.rs2))};
      OP_SUB:  quick_s = bus.rs1 - bus.rs2;
      OP_XOR:  quick_s = bus.rs1 ^ bus.rs2;
      OP_SRL:  quick_s = bus.rs1 >> sh_s;
      OP_SRA:  quick_s = $signed(bus.rs1) >>> sh_s;
`ifdef SEQ_ALU_MULDIV_EN
      OP_DIV:  quick_s = div0_s ? {N{1'b1}} : (ovf_s ? bus.rs1 : {N{1'b0}});
      OP_DIVU: quick_s = div0_s ? {N{1'b1}} : {N{1'b0}};
      OP_REM:  quick_s = div0_s ? bus.rs1 : {N{1'b0}};
      OP_REMU: quick_s = div0_s ? bus.rs1 : {N{1'b0}};
`endif
      default: quick_s = {N{1'b0}};
    endcase
  end

  // Next-state and load strobes
  always_comb begin
    state_s      = state_r;
    load_quick_s = 1'b0;
    load_md_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          if (multi_s) begin
            state_s = ST_CALC;
          end else begin
            state_s      = ST_DONE;
            load_quick_s = 1'b1;
          end
        end else if ((state_r == ST_DONE) && !bus.out_ready) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (md_done_s) begin
          state_s   = ST_DONE;
          load_md_s = 1'b1;
        end else begin
          state_s = ST_CALC;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  assign res_nxt_s = load_md_s ? md_res_s : quick_s;

  // Result and flags only move when a new result lands, so they hold under back-pressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_r <= {N{1'b0}};
      zf_r  <= 1'b0;
      neg_r <= 1'b0;
    end else if (load_quick_s || load_md_s) begin
      res_r <= res_nxt_s;
      zf_r  <= (res_nxt_s == {N{1'b0}});
      neg_r <= res_nxt_s[N-1];
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_r == ST_DONE);
  assign bus.res       = res_r;
  assign bus.zf        = zf_r;
  assign bus.negative  = neg_r;

endmodule
